// File: rtl/seq_det_sched.sv
// Time-shares one serial "sequence detector" among N requesters: arbitrate, shift the winner's word in MSB first, count det_out hits, report.
// Optional build macro ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module seq_det_sched #(
   parameter int N = 4,
   parameter int W = 8,
   localparam int CW = $clog2(W + 1),
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic           clock,
   input  logic           reset,
   input  logic [N-1:0]   req,
   input  logic [N*W-1:0] frame_bits,
   output logic [N-1:0]   grant,
   output logic           det_rst,
   output logic           det_in,
   input  logic           det_out,
   output logic           busy,
   output logic           done,
   output logic [IW-1:0]  done_id,
   output logic [CW-1:0]  hit_count
);

   typedef enum logic [2:0] {IDLE, ARB, SHIFT, DRAIN, REPORT} state_t;

   state_t        state_reg, state_next;
   logic [W-1:0]  word [N];
   logic [W-1:0]  shift_reg;
   logic [CW-1:0] bit_reg;
   logic [CW-1:0] cnt_reg;
   logic [CW-1:0] hit_count_reg;
   logic [IW-1:0] win_idx;
   logic [IW-1:0] win_reg;
   logic [IW-1:0] done_id_reg;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_word
         assign word[gi] = frame_bits[gi*W +: W];
      end
   endgenerate

`ifdef ARB_FIXED_PRIO_EN
   always_comb begin : winner_select
      logic found;
      found   = 1'b0;
      win_idx = '0;
      for (int i = 0; i < N; i++) begin
         if (!found && req[i]) begin
            found   = 1'b1;
            win_idx = IW'(i);
         end
      end
   end
`else
   logic [IW-1:0] ptr_reg;

   // Search starts at the pointer and wraps, so the last winner goes to the back of the line.
   always_comb begin : winner_select
      logic          found;
      logic [IW-1:0] idx;
      int            j;
      found   = 1'b0;
      win_idx = '0;
      idx     = '0;
      j       = 0;
      for (int i = 0; i < N; i++) begin
         j = int'(ptr_reg) + i;
         if (j >= N) j = j - N;
         idx = IW'(j);
         if (!found && req[idx]) begin
            found   = 1'b1;
            win_idx = idx;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         ptr_reg <= '0;
      else if (state_reg == ARB)
         ptr_reg <= (win_idx == IW'(N - 1)) ? '0 : win_idx + 1'b1;
   end
`endif

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (|req) state_next = ARB;
         ARB:     state_next = SHIFT;
         SHIFT:   if (bit_reg == CW'(W - 1)) state_next = DRAIN;
         DRAIN:   state_next = REPORT;
         REPORT:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg     <= IDLE;
         shift_reg     <= '0;
         bit_reg       <= '0;
         cnt_reg       <= '0;
         win_reg       <= '0;
         hit_count_reg <= '0;
         done_id_reg   <= '0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            ARB: begin
               win_reg   <= win_idx;
               shift_reg <= word[win_idx];
               bit_reg   <= '0;
               cnt_reg   <= '0;
            end
            SHIFT: begin
               shift_reg <= shift_reg << 1;
               bit_reg   <= bit_reg + 1'b1;
               // det_out on the first shift cycle answers nothing we sent
               if (bit_reg != '0 && det_out) cnt_reg <= cnt_reg + 1'b1;
            end
            DRAIN: begin
               hit_count_reg <= cnt_reg + CW'(det_out);
               done_id_reg   <= win_reg;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      grant  = '0;
      det_in = 1'b0;
      case (state_reg)
         ARB:     grant[win_idx] = 1'b1;
         SHIFT: begin
            grant[win_reg] = 1'b1;
            det_in         = shift_reg[W-1];
         end
         DRAIN:   grant[win_reg] = 1'b1;
         default: ;
      endcase
   end

   // Detector is held in reset while we are, and for the single ARB cycle.
   assign det_rst   = !reset || (state_reg == ARB);
   assign busy      = (state_reg != IDLE);
   assign done      = (state_reg == REPORT);
   assign done_id   = done_id_reg;
   assign hit_count = hit_count_reg;

endmodule

// File: tb/tb_seq_det_sched.sv
// Self-checking bench for seq_det_sched: directed frames plus randomized traffic against a timeline model.
// Detector stub flags "101" (overlap allowed) one cycle after the last bit; cleared by det_rst.
module tb_seq_det_sched;
   localparam int N  = 4;
   localparam int W  = 8;
   localparam int CW = $clog2(W + 1);
   localparam int IW = 2;

   logic           clock = 1'b0;
   logic           reset = 1'b0;
   logic [N-1:0]   req = '0;
   logic [N*W-1:0] frame_bits = '0;
   logic [N-1:0]   grant;
   logic           det_rst, det_in, det_out, busy, done;
   logic [IW-1:0]  done_id;
   logic [CW-1:0]  hit_count;

   seq_det_sched #(.N(N), .W(W)) dut (
      .clock(clock), .reset(reset), .req(req), .frame_bits(frame_bits),
      .grant(grant), .det_rst(det_rst), .det_in(det_in), .det_out(det_out),
      .busy(busy), .done(done), .done_id(done_id), .hit_count(hit_count)
   );

   always #5 clock = ~clock;

   logic [2:0] hist = 3'b000;
   always @(posedge clock) hist <= det_rst ? 3'b000 : {hist[1:0], det_in};
   assign det_out = (hist == 3'b101);

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   bit rand_en = 1'b0;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: frame timeline as a phase number (-1 idle, 0 arbitration, 1..W bits, W+1 drain, W+2 report).
   int           m_phase = -1;
   int           m_ptr = 0;
   int           m_win = 0;
   int           m_id = 0;
   int           m_hits = 0;
   logic [W-1:0] m_word = '0;

   function automatic int pick(input logic [N-1:0] r, input int p);
`ifdef ARB_FIXED_PRIO_EN
      for (int i = 0; i < N; i++) if (r[i]) return i;
`else
      for (int d = 0; d < N; d++) if (r[(p + d) % N]) return (p + d) % N;
`endif
      return 0;
   endfunction

   function automatic int count_101(input logic [W-1:0] w);
      int c = 0;
      for (int k = 2; k < W; k++)
         if (w[W+1-k] && !w[W-k] && w[W-1-k]) c++;
      return c;
   endfunction

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_phase <= -1;
         m_ptr   <= 0;
         m_id    <= 0;
         m_hits  <= 0;
      end else if (m_phase == -1) begin
         if (req != '0) m_phase <= 0;
      end else if (m_phase == 0) begin
         m_win   <= pick(req, m_ptr);
         m_word  <= frame_bits[pick(req, m_ptr)*W +: W];
         m_ptr   <= (pick(req, m_ptr) + 1) % N;
         m_phase <= 1;
      end else if (m_phase == W + 1) begin
         m_id    <= m_win;
         m_hits  <= count_101(m_word);
         m_phase <= W + 2;
      end else if (m_phase == W + 2) begin
         m_phase <= -1;
      end else begin
         m_phase <= m_phase + 1;
      end
   end

   logic [N-1:0] exp_grant;
   logic         exp_din;
   always @(negedge clock) begin
      if (reset) begin
         exp_grant = '0;
         exp_din   = 1'b0;
         if (m_phase == 0) exp_grant[pick(req, m_ptr)] = 1'b1;
         else if (m_phase >= 1 && m_phase <= W + 1) exp_grant[m_win] = 1'b1;
         if (m_phase >= 1 && m_phase <= W) exp_din = m_word[W-m_phase];
         check("busy", busy, m_phase >= 0);
         check("done", done, m_phase == W + 2);
         check("det_rst", det_rst, m_phase == 0);
         check("det_in", det_in, exp_din);
         check("grant", grant, exp_grant);
         check("done_id", done_id, m_id);
         check("hit_count", hit_count, m_hits);
      end
   end

   // Random traffic: req moves only after arbitration or to start a frame from idle; words never move during arbitration.
   always @(negedge clock) begin
      if (rand_en) begin
         if (m_phase >= 1 && $urandom_range(0, 3) == 0) req = N'($urandom);
         else if (m_phase == -1 && req == '0 && $urandom_range(0, 2) == 0) req = N'($urandom_range(1, 15));
         if (m_phase != 0 && $urandom_range(0, 2) == 0) frame_bits = {$urandom};
      end
   end

   task automatic wait_busy(input string name);
      for (int t = 0; t < 20; t++) begin
         @(negedge clock);
         if (busy) break;
      end
      check({name, "_start"}, busy, 1'b1);
   endtask

   // Called at the negedge of the arbitration cycle; returns at the negedge of the report cycle.
   // mode 1 drops req in the first shift cycle, mode 2 drops req and flips all words mid-shift.
   task automatic observe_frame(input int mode, output int lat, output logic [W-1:0] seq,
                                output int gcnt, output int rcnt, output logic [N-1:0] g0);
      g0 = grant; lat = -1; gcnt = 0; rcnt = 0; seq = '0;
      for (int i = 0; i <= W + 2; i++) begin
         if (i > 0) @(negedge clock);
         if (i >= 1 && i <= W) seq[W-i] = det_in;
         if (g0 != '0 && grant == g0) gcnt++;
         if (det_rst) rcnt++;
         if (done && lat < 0) lat = i;
         if (mode == 1 && i == 1) req = '0;
         if (mode == 2 && i == 3) begin
            req = '0;
            frame_bits = ~frame_bits;
         end
      end
   endtask

   int           lat, gcnt, rcnt, arb_prev, cnt_done, cnt_busy;
   logic [W-1:0] seq;
   logic [N-1:0] g0;
   int           rr_exp [5];
   int           p6_exp [3];

   initial begin
`ifdef ARB_FIXED_PRIO_EN
      rr_exp = '{0, 0, 0, 0, 0};
      p6_exp = '{1, 1, 1};
`else
      rr_exp = '{0, 1, 2, 3, 0};
      p6_exp = '{3, 1, 3};
`endif
      // Reset state
      repeat (2) @(negedge clock);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_grant", grant, '0);
      check("rst_det_in", det_in, 1'b0);
      check("rst_det_rst", det_rst, 1'b1);
      check("rst_done_id", done_id, '0);
      check("rst_hit_count", hit_count, '0);
      reset = 1'b1;
      @(negedge clock);
      check("idle_det_rst", det_rst, 1'b0);

      // Single frame, word0 = AA
      frame_bits = {8'h11, 8'h22, 8'h33, 8'hAA};
      req = 4'b0001;
      wait_busy("t2");
      observe_frame(1, lat, seq, gcnt, rcnt, g0);
      check("t2_grant", g0, 4'b0001);
      check("t2_grant_cycles", gcnt, 10);
      check("t2_det_in_seq", seq, 8'hAA);
      check("t2_latency", lat, 10);
      check("t2_hit_count", hit_count, 3);
      check("t2_done_id", done_id, 0);
      check("t2_det_rst_pulses", rcnt, 1);

      // No match, word2 = 00
      frame_bits = {8'hFF, 8'h00, 8'hFF, 8'hFF};
      req = 4'b0100;
      wait_busy("t3");
      observe_frame(1, lat, seq, gcnt, rcnt, g0);
      check("t3_grant", g0, 4'b0100);
      check("t3_hit_count", hit_count, 0);
      check("t3_done_id", done_id, 2);
      check("t3_det_rst_pulses", rcnt, 1);

      // Reset mid-shift aborts the frame
      @(negedge clock);
      frame_bits = {4{8'hB5}};
      req = 4'b0001;
      wait_busy("t1");
      repeat (3) @(negedge clock);
      req = '0;
      #2 reset = 1'b0;
      #1;
      check("t1_busy", busy, 1'b0);
      check("t1_grant", grant, '0);
      check("t1_det_in", det_in, 1'b0);
      check("t1_det_rst", det_rst, 1'b1);
      check("t1_done_id", done_id, '0);
      check("t1_hit_count", hit_count, '0);
      @(negedge clock);
      reset = 1'b1;
      cnt_done = 0;
      cnt_busy = 0;
      repeat (15) begin
         @(negedge clock);
         if (done) cnt_done++;
         if (busy) cnt_busy++;
      end
      check("t1_no_done", cnt_done, 0);
      check("t1_stays_idle", cnt_busy, 0);

      // Round-robin with all requests held
      frame_bits = {8'h5A, 8'hA5, 8'h0F, 8'hF0};
      req = 4'b1111;
      arb_prev = 0;
      for (int f = 0; f < 5; f++) begin
         wait_busy("t4");
         if (f > 0) check("t4_period", cyc - arb_prev, 12);
         arb_prev = cyc;
         observe_frame(0, lat, seq, gcnt, rcnt, g0);
         check("t4_grant", g0, 4'b0001 << rr_exp[f]);
         check("t4_done_id", done_id, rr_exp[f]);
      end
      req = '0;
      @(negedge clock);

      // Late req drop and word change
      frame_bits = {8'h00, 8'h00, 8'hB5, 8'h00};
      req = 4'b0010;
      wait_busy("t5");
      observe_frame(2, lat, seq, gcnt, rcnt, g0);
      check("t5_det_in_seq", seq, 8'hB5);
      check("t5_grant_cycles", gcnt, 10);
      check("t5_hit_count", hit_count, 3);
      check("t5_done_id", done_id, 1);
      @(negedge clock);

      // Requests 1 and 3 held
      frame_bits = {8'hAB, 8'hCD, 8'hEF, 8'h12};
      req = 4'b1010;
      for (int f = 0; f < 3; f++) begin
         wait_busy("t6");
         observe_frame(0, lat, seq, gcnt, rcnt, g0);
         check("t6_grant", g0, 4'b0001 << p6_exp[f]);
      end
      req = '0;
      @(negedge clock);

      rand_en = 1'b1;
      repeat (3000) @(negedge clock);
      rand_en = 1'b0;
      req = '0;
      repeat (20) @(negedge clock);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #400000;
      n_fail++;
      $display("FAIL watchdog: simulation still running at cycle %0d, expected to have ended", cyc);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $fatal(1, "watchdog expired");
   end
endmodule
